gravacao_rec_play_ctrl: RTL and testbench
=========================================

// Module: gravacao_rec_play_ctrl
// PURPOSE
//  Sequencer that shares one single-port sample RAM between a record stream and a playback stream.
//  Sits between tt_um_gravacao pin logic and gravacao_sample_ram.
//  Commands: record, play, stop.
//  Tracks recorded length; plays once or in a loop.
// PARAMETERS
//  DATA_W  8  sample width
//  ADDR_W  6  RAM address width; DEPTH = 2**ADDR_W samples
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  cmd_rec    in   1       start record (1-cycle pulse)
//  cmd_play   in   1       start playback (1-cycle pulse)
//  cmd_stop   in   1       abort record/playback
//  loop_en    in   1       sampled each wrap; 1 = restart at addr 0
//  in_valid   in   1       record sample valid
//  in_data    in   DATA_W  record sample
//  in_ready   out  1       controller accepts in_data this cycle
//  out_valid  out  1       playback sample valid
//  out_data   out  DATA_W  playback sample (registered)
//  out_ready  in   1       consumer accepts out_data
//  mem_en     out  1       RAM access strobe
//  mem_we     out  1       1 = write, 0 = read
//  mem_addr   out  ADDR_W  RAM address
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data; valid exactly 1 cycle after a read strobe
//  state_o    out  2       current FSM state
//  rec_len    out  ADDR_W+1  samples stored, 0..DEPTH
//  full       out  1       last record filled DEPTH samples
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; all outputs 0; rec_len 0; RAM contents untouched.
//  States: IDLE=0, REC=1, PLAY_RD=2, PLAY_OUT=3.
//  Command priority: stop > rec > play.
//   - rec/play are honoured only in IDLE.
//   - stop in IDLE has no effect.
//  IDLE + cmd_rec:
//   - ptr=0, rec_len=0, full=0; ->REC.
//  IDLE + cmd_play:
//   - rec_len==0: ignored, stays IDLE.
//   - otherwise ptr=0; ->PLAY_RD.
//  REC:
//   - in_ready=1 (combinational, state-based only).
//   - On in_valid: mem_en=mem_we=1, mem_addr=ptr, mem_wdata=in_data (same cycle); ptr++.
//   - Write of addr DEPTH-1: rec_len=DEPTH, full=1, ->IDLE. No wrap, no overwrite.
//   - cmd_stop: rec_len=ptr (writes done so far), ->IDLE.
//   - stop and in_valid in the same cycle: sample NOT written, in_ready=0 that cycle.
//  PLAY_RD:
//   - Issue read: mem_en=1, mem_we=0, mem_addr=ptr.
//   - Next cycle: out_data<=mem_rdata, out_valid<=1; ->PLAY_OUT.
//  PLAY_OUT:
//   - Hold out_data/out_valid until out_ready (AXI-style: no drop, no change while stalled).
//   - On accept with ptr<rec_len-1: ptr++, out_valid<=0, ->PLAY_RD.
//   - On accept with ptr==rec_len-1:
//     - loop_en=1: ptr=0, ->PLAY_RD.
//     - loop_en=0: ->IDLE.
//  Throughput: 1 sample per 2 cycles min; first out_valid 2 cycles after cmd_play.
//  cmd_stop in PLAY_*: out_valid=0 next cycle, pending sample discarded, ->IDLE; rec_len kept.
//  mem_en=0 in IDLE and PLAY_OUT.
//  ptr is ADDR_W bits and never exceeds DEPTH-1.
// STRUCTURE
//  gravacao_pkg:
//   - state localparams IDLE/REC/PLAY_RD/PLAY_OUT (2-bit encoding above)
//   - default DATA_W/ADDR_W
//  Single flat FSM + ptr/len counters. No sub-module.
//  gravacao_sample_ram (1-cycle sync read) is a sibling, instantiated by the top.
// TESTING (bench uses gravacao_sample_ram model, ADDR_W=6)
//  T1 reset: rst pulse mid-REC -> all outputs 0, state_o=0, rec_len=0 within same cycle.
//  T2 record: cmd_rec, 5 samples 0x11..0x15 (in_valid gaps) -> rec_len=5, full=0, RAM[0..4] = data.
//  T3 play once: cmd_play, loop_en=0, out_ready held low 3 cycles on 1st sample ->
//     out_data stays 0x11; sequence 0x11..0x15; then state_o=0.
//  T4 loop: loop_en=1 -> 0x11..0x15,0x11,0x12; cmd_stop -> out_valid=0 next cycle, IDLE.
//  T5 full: cmd_rec, 64 samples 0x00..0x3F, no stop -> rec_len=64, full=1, IDLE; in_ready=0 after.
//  T6 edges:
//   - cmd_play with rec_len=0 -> stays IDLE, mem_en never asserted.
//   - cmd_stop with in_valid in REC -> sample not written.

Source files
------------

// File: rtl/gravacao_pkg.sv
// gravacao_pkg: shared state encoding and default widths for the record/playback sequencer.
package gravacao_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REC      = 2'd1,
    PLAY_RD  = 2'd2,
    PLAY_OUT = 2'd3
  } state_t;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
endpackage

// File: rtl/gravacao_rec_play_ctrl.sv
// gravacao_rec_play_ctrl: shares one single-port sample RAM between a record stream and a playback stream.
module gravacao_rec_play_ctrl
  import gravacao_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_rec,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              loop_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   rec_len,
  output logic              full
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              full_q, full_d, valid_q, valid_d, fresh_q, fresh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last;

  // The RAM output register is shown directly in the first PLAY_OUT cycle, then held locally.
  assign out_data  = fresh_q ? mem_rdata : data_q;
  assign out_valid = valid_q;
  assign mem_addr  = mem_en ? ptr_q : '0;
  assign mem_wdata = mem_we ? in_data : '0;
  assign state_o   = state_q;
  assign rec_len   = len_q;
  assign full      = full_q;
  assign last      = {1'b0, ptr_q} == len_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    full_d   = full_q;
    valid_d  = valid_q;
    fresh_d  = 1'b0;
    data_d   = out_data;
    in_ready = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cmd_stop && cmd_rec) begin
          ptr_d   = '0;
          len_d   = '0;
          full_d  = 1'b0;
          state_d = REC;
        end else if (!cmd_stop && cmd_play && len_q != '0) begin
          ptr_d   = '0;
          state_d = PLAY_RD;
        end
      end
      REC: begin
        in_ready = !cmd_stop;
        if (cmd_stop) begin
          len_d   = {1'b0, ptr_q};
          state_d = IDLE;
        end else if (in_valid) begin
          mem_en = 1'b1;
          mem_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          if (&ptr_q) begin
            len_d   = {1'b1, {ADDR_W{1'b0}}};
            full_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      PLAY_RD: begin
        mem_en  = !cmd_stop;
        valid_d = !cmd_stop;
        fresh_d = !cmd_stop;
        state_d = cmd_stop ? IDLE : PLAY_OUT;
      end
      PLAY_OUT: begin
        if (cmd_stop) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (out_ready) begin
          valid_d = 1'b0;
          ptr_d   = last ? '0 : ptr_q + ADDR_W'(1);
          state_d = (last && !loop_en) ? IDLE : PLAY_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_gravacao_rec_play_ctrl.sv
// tb_gravacao_rec_play_ctrl: directed bench for the record/playback sequencer with a 1-cycle sync-read RAM model.
module tb_gravacao_rec_play_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       cmd_rec = 0, cmd_play = 0, cmd_stop = 0, loop_en = 0;
  logic       in_valid = 0, out_ready = 0;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, mem_en, mem_we, full;
  logic [7:0] out_data, mem_wdata, mem_rdata;
  logic [5:0] mem_addr;
  logic [1:0] state_o;
  logic [6:0] rec_len;
  logic [7:0] ram [64];
  int         n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  gravacao_rec_play_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .cmd_rec(cmd_rec), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
    .loop_en(loop_en), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_o(state_o), .rec_len(rec_len), .full(full)
  );

  initial for (int i = 0; i < 64; i++) ram[i] = 8'h00;
  initial mem_rdata = 8'h00;

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic       rec, play, stop, vld;
    logic [7:0] din;
    logic [1:0] e_state;
    logic       e_rdy, e_en, e_we;
    logic [5:0] e_addr;
  } vec_t;
  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic recv(input logic [7:0] exp);
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    chk("recv_valid", {31'b0, out_valid}, 1);
    chk("recv_data", {24'b0, out_data}, {24'b0, exp});
    tick();
  endtask

  initial begin
    vecs[0]  = '{0,1,0,0,8'h00, 2'd0, 0,0,0, 6'd0};
    vecs[1]  = '{0,0,0,0,8'h00, 2'd0, 0,0,0, 6'd0};
    vecs[2]  = '{1,0,0,0,8'h00, 2'd0, 0,0,0, 6'd0};
    vecs[3]  = '{0,0,0,1,8'h11, 2'd1, 1,1,1, 6'd0};
    vecs[4]  = '{0,0,0,0,8'h99, 2'd1, 1,0,0, 6'd0};
    vecs[5]  = '{0,0,0,1,8'h12, 2'd1, 1,1,1, 6'd1};
    vecs[6]  = '{0,0,0,1,8'h13, 2'd1, 1,1,1, 6'd2};
    vecs[7]  = '{0,0,0,0,8'h00, 2'd1, 1,0,0, 6'd0};
    vecs[8]  = '{0,0,0,0,8'h00, 2'd1, 1,0,0, 6'd0};
    vecs[9]  = '{0,0,0,1,8'h14, 2'd1, 1,1,1, 6'd3};
    vecs[10] = '{0,0,0,1,8'h15, 2'd1, 1,1,1, 6'd4};
    vecs[11] = '{0,0,1,0,8'h00, 2'd1, 0,0,0, 6'd0};
    vecs[12] = '{0,0,0,0,8'h00, 2'd0, 0,0,0, 6'd0};

    #12;
    chk("rst_state", {30'b0, state_o}, 0);
    chk("rst_outs", {28'b0, out_valid, mem_en, in_ready, full}, 0);
    chk("rst_len", {25'b0, rec_len}, 0);
    rst = 1'b0;
    tick();

    // Play with nothing recorded, then record 5 samples with gaps and stop.
    foreach (vecs[i]) begin
      {cmd_rec, cmd_play, cmd_stop, in_valid} = {vecs[i].rec, vecs[i].play, vecs[i].stop, vecs[i].vld};
      in_data = vecs[i].din;
      #1;
      chk($sformatf("vec%0d_state", i), {30'b0, state_o}, {30'b0, vecs[i].e_state});
      chk($sformatf("vec%0d_rdy_en_we", i), {29'b0, in_ready, mem_en, mem_we},
          {29'b0, vecs[i].e_rdy, vecs[i].e_en, vecs[i].e_we});
      if (vecs[i].e_en) chk($sformatf("vec%0d_addr", i), {26'b0, mem_addr}, {26'b0, vecs[i].e_addr});
      tick();
    end
    {cmd_rec, cmd_play, cmd_stop, in_valid} = '0;
    chk("t2_len", {25'b0, rec_len}, 5);
    chk("t2_full", {31'b0, full}, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_ram%0d", i), {24'b0, ram[i]}, 32'h11 + i);

    // Play once with a 3-cycle stall on the first sample.
    loop_en = 0; out_ready = 0; cmd_play = 1;
    tick();
    cmd_play = 0;
    #1;
    chk("t3_rd_state", {30'b0, state_o}, 2);
    chk("t3_rd_mem", {30'b0, mem_en, mem_we}, 2'b10);
    chk("t3_rd_addr", {26'b0, mem_addr}, 0);
    chk("t3_rd_nvalid", {31'b0, out_valid}, 0);
    tick();
    chk("t3_first_valid", {31'b0, out_valid}, 1);
    chk("t3_first_data", {24'b0, out_data}, 32'h11);
    chk("t3_out_memen", {31'b0, mem_en}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_stall_valid", {31'b0, out_valid}, 1);
      chk("t3_stall_data", {24'b0, out_data}, 32'h11);
    end
    out_ready = 1;
    for (int i = 0; i < 5; i++) recv(8'h11 + 8'(i));
    chk("t3_end_state", {30'b0, state_o}, 0);
    chk("t3_end_valid", {31'b0, out_valid}, 0);

    // Loop playback, then stop while a sample is pending.
    loop_en = 1; cmd_play = 1;
    tick();
    cmd_play = 0;
    for (int i = 0; i < 7; i++) recv(8'h11 + 8'(i % 5));
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    chk("t4_pending", {24'b0, out_data}, 32'h13);
    out_ready = 0; cmd_stop = 1;
    tick();
    cmd_stop = 0; loop_en = 0;
    #1;
    chk("t4_stop_valid", {31'b0, out_valid}, 0);
    chk("t4_stop_state", {30'b0, state_o}, 0);
    chk("t4_len_kept", {25'b0, rec_len}, 5);

    // Stop coincident with in_valid drops the sample.
    cmd_rec = 1;
    tick();
    cmd_rec = 0; in_valid = 1; in_data = 8'hA0;
    #1;
    chk("t6_wr_en", {31'b0, mem_en}, 1);
    tick();
    in_data = 8'hA1; cmd_stop = 1;
    #1;
    chk("t6_stop_rdy", {31'b0, in_ready}, 0);
    chk("t6_stop_en", {31'b0, mem_en}, 0);
    tick();
    cmd_stop = 0; in_valid = 0;
    #1;
    chk("t6_state", {30'b0, state_o}, 0);
    chk("t6_len", {25'b0, rec_len}, 1);
    chk("t6_ram0", {24'b0, ram[0]}, 32'hA0);
    chk("t6_ram1", {24'b0, ram[1]}, 32'h12);

    // Asynchronous reset in the middle of a record.
    cmd_rec = 1;
    tick();
    cmd_rec = 0; in_valid = 1; in_data = 8'h55;
    #1;
    chk("t1_in_rec", {30'b0, state_o}, 1);
    #2 rst = 1;
    #1;
    chk("t1_state", {30'b0, state_o}, 0);
    chk("t1_outs", {26'b0, in_ready, out_valid, mem_en, mem_we, full, 1'b0}, 0);
    chk("t1_bus", {10'b0, mem_addr, mem_wdata, out_data}, 0);
    chk("t1_len", {25'b0, rec_len}, 0);
    in_valid = 0;
    #1 rst = 0;
    tick();

    // Fill all 64 locations; recording must end by itself without wrapping.
    cmd_rec = 1;
    tick();
    cmd_rec = 0;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1; in_data = 8'(i);
      #1;
      if (i % 16 == 15) chk($sformatf("t5_addr%0d", i), {26'b0, mem_addr}, i);
      tick();
    end
    in_data = 8'h40;
    #1;
    chk("t5_state", {30'b0, state_o}, 0);
    chk("t5_len", {25'b0, rec_len}, 64);
    chk("t5_full", {31'b0, full}, 1);
    chk("t5_rdy_en", {30'b0, in_ready, mem_en}, 0);
    tick();
    in_valid = 0;
    chk("t5_ram0", {24'b0, ram[0]}, 0);
    chk("t5_ram63", {24'b0, ram[63]}, 32'h3F);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
